// File: rtl/bingo_if.sv
// Draw handshake and card-RAM bus shared by the bingo engine and its environment.
// Ports: draw_valid/draw_number/draw_ready, ram_addr/ram_rd_data/ram_we/ram_wdata.
interface bingo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  draw_valid;
    logic [DATA_WIDTH-1:0] draw_number;
    logic                  draw_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;

    modport master (
        output draw_valid, draw_number, ram_rd_data,
        input  draw_ready, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  draw_valid, draw_number, ram_rd_data,
        output draw_ready, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/bingo_engine.sv
// Bingo engine: accepts paced draws, scans all card entries in RAM, marks and
// deletes every hit, then checks for winning players.
// Ports: clk, rstn (sync, active-low), start_game, bus (bingo_if.slave),
// marks, winner_mask, game_over, busy, draw_count, last_number.
module bingo_engine #(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_PLAYERS        = 2,
    parameter int ENTRIES_PER_PLAYER = 8,
    parameter int ADDR_WIDTH         = 4,
    parameter int DRAW_INTERVAL      = 50
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       start_game,
    bingo_if.slave                                     bus,
    output logic [NUM_PLAYERS*ENTRIES_PER_PLAYER-1:0]  marks,
    output logic [NUM_PLAYERS-1:0]                     winner_mask,
    output logic                                       game_over,
    output logic                                       busy,
    output logic [7:0]                                 draw_count,
    output logic [DATA_WIDTH-1:0]                      last_number
);
    localparam int NE = NUM_PLAYERS * ENTRIES_PER_PLAYER;
    localparam int CW = $clog2(DRAW_INTERVAL + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NE - 1);
    localparam logic [CW-1:0] INTERVAL = CW'(DRAW_INTERVAL);

    typedef enum logic [2:0] {
        IDLE, WAIT, READ, CMP, MARK, CHECK, DONE
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  restart;
    logic                  accept;
    logic                  hit;
    logic                  at_last;
    logic [NUM_PLAYERS-1:0] win;

    always_comb begin
        win = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            win[p] = &marks[p*ENTRIES_PER_PLAYER +: ENTRIES_PER_PLAYER];
        end
    end

    assign bus.draw_ready = (state == WAIT) && (cnt == '0);
    assign bus.ram_addr   = addr;
    assign bus.ram_we     = (state == MARK);
    assign bus.ram_wdata  = '0;

    assign busy      = (state == READ) || (state == CMP) ||
                       (state == MARK) || (state == CHECK);
    assign game_over = (state == DONE);

    // Restart is only honoured outside a scan; it takes priority over a draw.
    assign restart = start_game &&
                     ((state == IDLE) || (state == WAIT) || (state == DONE));
    assign accept  = bus.draw_ready && bus.draw_valid && !start_game;
    // Already-marked entries are skipped so duplicates are marked only once.
    assign hit     = (bus.ram_rd_data == last_number) &&
                     (last_number != '0) && !marks[addr];
    assign at_last = (addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (restart) state_nxt = WAIT;
            WAIT: begin
                if (restart)     state_nxt = WAIT;
                else if (accept) state_nxt = READ;
            end
            READ:  state_nxt = CMP;
            CMP: begin
                if (hit)          state_nxt = MARK;
                else if (at_last) state_nxt = CHECK;
                else              state_nxt = READ;
            end
            MARK:  state_nxt = at_last ? CHECK : READ;
            CHECK: state_nxt = (win != '0) ? DONE : WAIT;
            DONE:  if (restart) state_nxt = WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt         <= '0;
            addr        <= '0;
            marks       <= '0;
            winner_mask <= '0;
            draw_count  <= '0;
            last_number <= '0;
        end else if (restart) begin
            cnt         <= INTERVAL;
            addr        <= '0;
            marks       <= '0;
            winner_mask <= '0;
            draw_count  <= '0;
            last_number <= '0;
        end else begin
            unique case (state)
                WAIT: begin
                    if (accept) begin
                        last_number <= bus.draw_number;
                        addr        <= '0;
                        if (draw_count != 8'hFF) begin
                            draw_count <= draw_count + 8'd1;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CMP: begin
                    if (!hit && !at_last) addr <= addr + ADDR_WIDTH'(1);
                end
                MARK: begin
                    marks[addr] <= 1'b1;
                    if (!at_last) addr <= addr + ADDR_WIDTH'(1);
                end
                CHECK: begin
                    winner_mask <= win;
                    cnt         <= INTERVAL;
                    addr        <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bingo_engine.sv
// Self-checking bench for bingo_engine with a behavioural card RAM and
// a set-based reference model of marks, winners and scan length.
module tb_bingo_engine;
    localparam int DW = 8;
    localparam int NP = 2;
    localparam int EP = 8;
    localparam int AW = 4;
    localparam int DI = 50;
    localparam int NE = NP * EP;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start_game = 1'b0;
    logic [NE-1:0] marks;
    logic [NP-1:0] winner_mask;
    logic game_over, busy;
    logic [7:0] draw_count;
    logic [DW-1:0] last_number;

    bingo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

    logic [DW-1:0] mem [NE];
    logic [DW-1:0] img [NE];
    logic load = 1'b0;

    int checks = 0;
    int fails = 0;
    int lat, gap, we_cnt;
    logic [NE-1:0] we_mask;
    bit we_ordered;

    int mcard [NE];
    logic [NE-1:0] mmarks;
    int mcount, mlast;

    always #5 clk = ~clk;

    bingo_engine #(
        .DATA_WIDTH(DW), .NUM_PLAYERS(NP), .ENTRIES_PER_PLAYER(EP),
        .ADDR_WIDTH(AW), .DRAW_INTERVAL(DI)
    ) dut (
        .clk(clk), .rstn(rstn), .start_game(start_game), .bus(bif.slave),
        .marks(marks), .winner_mask(winner_mask), .game_over(game_over),
        .busy(busy), .draw_count(draw_count), .last_number(last_number)
    );

    always @(posedge clk) begin
        if (load) mem <= img;
        else if (bif.ram_we) mem[bif.ram_addr] <= bif.ram_wdata;
        bif.ram_rd_data <= mem[bif.ram_addr];
    end

    task automatic set_card(input int i, input int v);
        img[i] = v[DW-1:0];
        mcard[i] = v;
    endtask

    task automatic load_ram();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic start();
        start_game = 1'b1;
        @(negedge clk);
        start_game = 1'b0;
        mmarks = '0;
        mcount = 0;
        mlast = 0;
    endtask

    task automatic model_draw(input int n, output logic [NE-1:0] h);
        h = '0;
        for (int i = 0; i < NE; i++)
            if (n != 0 && mcard[i] == n && !mmarks[i]) h[i] = 1'b1;
        mmarks |= h;
        if (mcount < 255) mcount++;
        mlast = n;
    endtask

    function automatic logic [NP-1:0] mwin();
        logic [NP-1:0] w;
        for (int p = 0; p < NP; p++) w[p] = &mmarks[p*EP +: EP];
        return w;
    endfunction

    task automatic record_scan();
        int g = 0;
        int prev = -1;
        lat = 0; we_mask = '0; we_cnt = 0; we_ordered = 1'b1;
        while (busy && g < 1000) begin
            lat++;
            if (bif.ram_we) begin
                if (int'(bif.ram_addr) <= prev) we_ordered = 1'b0;
                prev = int'(bif.ram_addr);
                we_mask[bif.ram_addr] = 1'b1;
                we_cnt++;
            end
            @(negedge clk);
            g++;
        end
    endtask

    task automatic do_draw(input int n);
        int g = 0;
        while (!bif.draw_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (!bif.draw_ready) begin
            fails++;
            $display("FAIL ready_timeout got=0 want=1");
            return;
        end
        bif.draw_valid = 1'b1;
        bif.draw_number = n[DW-1:0];
        @(negedge clk);
        bif.draw_valid = 1'b0;
        record_scan();
    endtask

    task automatic measure_gap();
        gap = 0;
        while (!bif.draw_ready && !game_over && gap < 1000) begin
            @(negedge clk);
            gap++;
        end
    endtask

    task automatic cards_seq();
        for (int i = 0; i < NE; i++) set_card(i, i + 1);
        load_ram();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({marks, winner_mask, game_over, busy, draw_count, last_number,
             bif.draw_ready, bif.ram_we, bif.ram_addr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs marks=%h win=%b go=%b busy=%b cnt=%0d rdy=%b we=%b",
                     marks, winner_mask, game_over, busy, draw_count,
                     bif.draw_ready, bif.ram_we);
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bif.draw_ready !== 1'b0 || busy !== 1'b0 || bif.ram_we !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset rdy=%b busy=%b we=%b want 0 0 0",
                     bif.draw_ready, busy, bif.ram_we);
        end
    endtask

    task automatic test_single_hit();
        logic [NE-1:0] h;
        cards_seq();
        start();
        measure_gap();
        checks++;
        if (gap != DI) begin
            fails++;
            $display("FAIL start_gap got=%0d want=%0d", gap, DI);
        end
        do_draw(5);
        model_draw(5, h);
        checks++;
        if (we_cnt != 1 || we_mask !== 16'h0010 || !we_ordered) begin
            fails++;
            $display("FAIL single_we cnt=%0d mask=%h want 1 0010", we_cnt, we_mask);
        end
        checks++;
        if (marks !== 16'h0010 || draw_count !== 8'd1 || last_number !== 8'd5) begin
            fails++;
            $display("FAIL single_state marks=%h cnt=%0d last=%0d want 0010 1 5",
                     marks, draw_count, last_number);
        end
        checks++;
        if (lat != 2 * NE + 2) begin
            fails++;
            $display("FAIL single_latency got=%0d want=%0d", lat, 2 * NE + 2);
        end
        checks++;
        if (mem[4] !== 8'd0 || mem[5] !== 8'd6) begin
            fails++;
            $display("FAIL delete_marker mem4=%0d mem5=%0d want 0 6", mem[4], mem[5]);
        end
        measure_gap();
        checks++;
        if (gap != DI) begin
            fails++;
            $display("FAIL draw_gap got=%0d want=%0d", gap, DI);
        end
    endtask

    task automatic test_duplicates();
        cards_seq();
        set_card(2, 7);
        load_ram();
        start();
        checks++;
        if (marks !== '0 || draw_count !== 8'd0 || last_number !== 8'd0) begin
            fails++;
            $display("FAIL restart_clear marks=%h cnt=%0d last=%0d want 0 0 0",
                     marks, draw_count, last_number);
        end
        do_draw(7);
        checks++;
        if (we_cnt != 2 || we_mask !== 16'h0044 || !we_ordered) begin
            fails++;
            $display("FAIL dup_we cnt=%0d mask=%h ord=%0b want 2 0044 1",
                     we_cnt, we_mask, we_ordered);
        end
        checks++;
        if (marks !== 16'h0044 || lat != 35) begin
            fails++;
            $display("FAIL dup_result marks=%h lat=%0d want 0044 35", marks, lat);
        end
    endtask

    task automatic test_win();
        cards_seq();
        start();
        for (int n = 9; n <= 16; n++) begin
            do_draw(n);
            if (n == 15) begin
                checks++;
                if (winner_mask !== 2'b00 || game_over !== 1'b0) begin
                    fails++;
                    $display("FAIL early_win win=%b go=%b want 00 0", winner_mask, game_over);
                end
            end
        end
        checks++;
        if (winner_mask !== 2'b10 || game_over !== 1'b1 || bif.draw_ready !== 1'b0) begin
            fails++;
            $display("FAIL win_p1 win=%b go=%b rdy=%b want 10 1 0",
                     winner_mask, game_over, bif.draw_ready);
        end
        repeat (DI + 10) @(negedge clk);
        checks++;
        if (marks !== 16'hFF00 || winner_mask !== 2'b10 || bif.draw_ready !== 1'b0) begin
            fails++;
            $display("FAIL done_hold marks=%h win=%b rdy=%b want ff00 10 0",
                     marks, winner_mask, bif.draw_ready);
        end
    endtask

    task automatic test_tie();
        bit early = 1'b0;
        bit bad_lat = 1'b0;
        for (int i = 0; i < NE; i++) set_card(i, (i % EP) + 1);
        load_ram();
        start();
        checks++;
        if (game_over !== 1'b0 || winner_mask !== 2'b00) begin
            fails++;
            $display("FAIL restart_from_done go=%b win=%b want 0 00", game_over, winner_mask);
        end
        for (int n = 1; n <= EP; n++) begin
            do_draw(n);
            if (lat != 2 * NE + 3) bad_lat = 1'b1;
            if (n < EP && winner_mask !== 2'b00) early = 1'b1;
        end
        checks++;
        if (winner_mask !== 2'b11 || early || game_over !== 1'b1) begin
            fails++;
            $display("FAIL tie win=%b early=%0b go=%b want 11 0 1", winner_mask, early, game_over);
        end
        checks++;
        if (bad_lat) begin
            fails++;
            $display("FAIL tie_latency got=%0d want=%0d", lat, 2 * NE + 3);
        end
    endtask

    task automatic test_zero();
        int n;
        cards_seq();
        set_card(3, 0);
        load_ram();
        start();
        for (int k = 1; k <= 2; k++) begin
            bif.draw_valid = 1'b1;
            bif.draw_number = '0;
            n = 0;
            while (!busy && n < 500) begin
                @(negedge clk);
                n++;
            end
            bif.draw_valid = 1'b0;
            checks++;
            if (n != DI + 1) begin
                fails++;
                $display("FAIL held_valid_wait got=%0d want=%0d", n, DI + 1);
            end
            record_scan();
            checks++;
            if (marks !== '0 || we_cnt != 0 || lat != 2 * NE + 1 ||
                draw_count !== 8'(k) || last_number !== 8'd0) begin
                fails++;
                $display("FAIL zero_draw marks=%h we=%0d lat=%0d cnt=%0d want 0 0 %0d %0d",
                         marks, we_cnt, lat, draw_count, 2 * NE + 1, k);
            end
        end
    endtask

    task automatic test_ignore_start();
        int g = 0;
        cards_seq();
        start();
        while (!bif.draw_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        bif.draw_valid = 1'b1;
        bif.draw_number = 8'd5;
        @(negedge clk);
        bif.draw_valid = 1'b0;
        repeat (4) @(negedge clk);
        start_game = 1'b1;
        @(negedge clk);
        start_game = 1'b0;
        record_scan();
        checks++;
        if (marks !== 16'h0010 || draw_count !== 8'd1 || lat != 2 * NE + 2 - 5) begin
            fails++;
            $display("FAIL start_in_scan marks=%h cnt=%0d lat=%0d want 0010 1 %0d",
                     marks, draw_count, lat, 2 * NE + 2 - 5);
        end
        repeat (5) @(negedge clk);
        start();
        checks++;
        if (marks !== '0 || draw_count !== 8'd0 || bif.draw_ready !== 1'b0) begin
            fails++;
            $display("FAIL start_in_wait marks=%h cnt=%0d rdy=%b want 0 0 0",
                     marks, draw_count, bif.draw_ready);
        end
    endtask

    task automatic test_reset_mid_scan();
        int g = 0;
        int bad = 0;
        cards_seq();
        start();
        do_draw(5);
        while (!bif.draw_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        bif.draw_valid = 1'b1;
        bif.draw_number = 8'd16;
        @(negedge clk);
        bif.draw_valid = 1'b0;
        repeat (8) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bif.ram_we !== 1'b0 || marks !== '0 ||
            draw_count !== 8'd0 || bif.ram_addr !== '0) begin
            fails++;
            $display("FAIL reset_mid_scan busy=%b we=%b marks=%h cnt=%0d addr=%0d want 0",
                     busy, bif.ram_we, marks, draw_count, bif.ram_addr);
        end
        rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NE; i++)
            if (mem[i] !== ((i == 4) ? 8'd0 : 8'(i + 1))) bad++;
        checks++;
        if (bad != 0 || bif.ram_we !== 1'b0) begin
            fails++;
            $display("FAIL ram_after_reset bad=%0d we=%b want 0 0", bad, bif.ram_we);
        end
    endtask

    task automatic test_random();
        logic [NE-1:0] h;
        int n;
        for (int game = 0; game < 3; game++) begin
            for (int i = 0; i < NE; i++) set_card(i, $urandom_range(1, 12));
            load_ram();
            start();
            for (int d = 0; d < 60; d++) begin
                n = $urandom_range(0, 12);
                do_draw(n);
                model_draw(n, h);
                checks++;
                if (lat != 2 * NE + $countones(h) + 1 || we_mask !== h ||
                    we_cnt != $countones(h) || !we_ordered) begin
                    fails++;
                    $display("FAIL rand_scan n=%0d lat=%0d we=%h want %0d %h",
                             n, lat, we_mask, 2 * NE + $countones(h) + 1, h);
                end
                checks++;
                if (marks !== mmarks || winner_mask !== mwin() ||
                    game_over !== (mwin() != '0) || draw_count !== 8'(mcount) ||
                    last_number !== 8'(mlast)) begin
                    fails++;
                    $display("FAIL rand_state marks=%h win=%b cnt=%0d want %h %b %0d",
                             marks, winner_mask, draw_count, mmarks, mwin(), mcount);
                end
                if (mwin() != '0 || game_over) break;
            end
        end
    endtask

    initial begin
        bif.draw_valid = 1'b0;
        bif.draw_number = '0;
        for (int i = 0; i < NE; i++) img[i] = '0;
        @(negedge clk);
        load_ram();
        test_reset();
        test_single_hit();
        test_duplicates();
        test_win();
        test_tie();
        test_zero();
        test_ignore_start();
        test_reset_mid_scan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/bingo_engine.md
BINGO_ENGINE -- requirements
Module: bingo_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_WIDTH 8 width of drawn numbers and RAM words;
  NUM_PLAYERS 2 number of player cards;
  ENTRIES_PER_PLAYER 8 entries per card;
  ADDR_WIDTH 4 RAM address width, SHALL satisfy 2**ADDR_WIDTH >= NUM_PLAYERS*ENTRIES_PER_PLAYER;
  DRAW_INTERVAL 50 minimum clocks between accepted draws, >= 1.
REQ-002 Ports (name direction width meaning), one per line:
  clk in 1 clock;
  rstn in 1 reset, synchronous, active-low;
  start_game in 1 one-cycle pulse, starts or restarts a game;
  draw_valid in 1 drawn number offered;
  draw_number in DATA_WIDTH drawn number;
  draw_ready out 1 engine accepts a draw this cycle;
  ram_addr out ADDR_WIDTH card RAM address;
  ram_rd_data in DATA_WIDTH RAM read data, valid one cycle after ram_addr;
  ram_we out 1 RAM write strobe;
  ram_wdata out DATA_WIDTH RAM write data, constant 0 (delete marker);
  marks out NUM_PLAYERS*ENTRIES_PER_PLAYER per-entry hit flags, bit i = RAM address i;
  winner_mask out NUM_PLAYERS one bit per winning player;
  game_over out 1 game finished;
  busy out 1 scan in progress;
  draw_count out 8 accepted draws this game, saturating at 255;
  last_number out DATA_WIDTH last accepted draw.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT, READ, CMP, MARK, CHECK and DONE.
REQ-004 IDLE: on start_game, clear marks, winner_mask, draw_count and last_number, load the interval counter with DRAW_INTERVAL, and go to WAIT.
REQ-005 WAIT: the interval counter decrements each cycle to 0. draw_ready=1 only when counter==0. A handshake is draw_valid&draw_ready; on it, capture last_number, increment draw_count (saturating), set ram_addr=0, and go to READ.
REQ-006 READ: drive ram_addr and go to CMP (one-cycle RAM latency). busy=1 in READ, CMP, MARK and CHECK.
REQ-007 CMP: a hit is ram_rd_data==last_number && last_number!=0 && marks[ram_addr]==0. On a hit go to MARK. Otherwise, if ram_addr is the last entry (N*E-1) go to CHECK, else increment ram_addr and go to READ.
REQ-008 MARK: ram_we=1 for exactly one cycle at ram_addr with ram_wdata=0, and set marks[ram_addr]. Then take the same last-entry/increment decision as CMP.
REQ-009 The scan SHALL cover every entry and mark all duplicates of the number; a draw never stops early on the first hit.
REQ-010 A draw of 0 SHALL be accepted and counted but SHALL never produce a hit.
REQ-011 CHECK: for each player p, winner_mask[p] = AND of marks[p*E +: E]. If winner_mask!=0, go to DONE; else reload the interval counter and go to WAIT.
REQ-012 Ties: every player completing on the same draw SHALL be flagged simultaneously.
REQ-013 DONE: game_over=1, and marks and winner_mask hold.
  - start_game in DONE or WAIT SHALL behave as in IDLE (restart).
  - start_game during a scan (busy=1) SHALL be ignored.
REQ-014 Addresses at or above N*E SHALL never be driven.
REQ-015 ram_we SHALL be 0 outside MARK. draw_ready SHALL be 0 outside WAIT.
REQ-016 Scan latency SHALL be 2*N*E + hits + 1 cycles from handshake to the CHECK decision.

Reset
REQ-017 While rstn=0 at a clk edge, the state SHALL become IDLE and all outputs SHALL be 0, including mid-scan. ram_we SHALL be 0 on the first cycle after reset.
REQ-018 No RAM content is altered by reset.

Verification
REQ-019 Reset mid-scan (assert rstn=0 at the 5th READ) -> next cycle: IDLE, ram_we=0, busy=0, marks=0.
REQ-020 Defaults, card0=1..8, card1=9..16; start, then draw 5 -> ram_we pulses once at addr 4; marks=0x0010; draw_count=1; draw_ready returns 50 cycles after CHECK.
REQ-021 Card0 holds 7 at addr 2 and addr 6; draw 7 -> two ram_we pulses (addr 2, then 6); marks=0x0044; scan length 35 cycles.
REQ-022 Draw 9..16 in sequence -> after the 8th CHECK: winner_mask=2'b10, game_over=1, draw_ready=0.
REQ-023 Tie, card0=card1=1..8; draw 1..8 -> winner_mask=2'b11 on the same CHECK.
REQ-024 Draw 0 and draw_valid held high during the interval -> no hit, draw_count increments, and handshakes occur only at counter 0.
